secuenciador_desplazamiento: RTL and testbench
==============================================

Name: secuenciador_desplazamiento

Overview:
Multi-cycle controller that sequences a single-bit right-shift datapath to perform an N-bit right shift by a variable amount.
- Three modes: logical, arithmetic and rotate.
- Start/busy/done handshake towards the MicroUAZ control unit.
- Registered result, carry-out and zero flags are fed back to the ALU status register.

Parameters:
N, 8, operand/result width in bits
CW, $clog2(N+1), width of the shift-count input (4 for N=8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  N  operand; sampled with start
CNT  input  CW  shift amount; sampled with start
MODO  input  2  mode select, sampled with start: 00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
Y  output  N  registered result; holds until the next commit
C  output  1  registered carry-out: last bit shifted out
Z  output  1  registered zero flag, (Y==0)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, high while in DONE

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of the current state:
  - state=IDLE, Y=0, C=0, Z=0, busy=0, done=0
  - internal R=0, rem=0, c_int=0
- Reset asserted mid-operation aborts it. No done pulse and no Y update follow.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, latch R<=A, rem<=min(CNT,N), modo_r<=MODO, c_int<=0, then go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT, rem!=0: apply one shift step, then stay in SHIFT.
  - R<=step(R, modo_r)
  - c_int<=R[0]
  - rem<=rem-1
- SHIFT, rem==0: commit, then go to DONE.
  - Y<=R, C<=c_int, Z<=(R==0)
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- step() per mode:
  - logical: {1'b0, R[N-1:1]}
  - arithmetic: {R[N-1], R[N-1:1]}
  - rotate: {R[0], R[N-1:1]}
- Latency: start sampled at edge t. Shifts occur at edges t+1..t+CNT, commit at edge t+CNT+1, done is high for the cycle after that edge. Total: CNT+2 cycles from start to done.
- CNT=0: no shift, Y=A, C=0, latency 2.
- CNT>N: clamped to N.
  - logical gives Y=0.
  - arithmetic gives all sign bits.
  - rotate gives Y=A.
  - C is the bit shifted out on the N-th step.
- start while busy=1 (SHIFT or DONE) is ignored and not queued. A, CNT and MODO may change freely while busy.
- Back-to-back operation: start asserted in the cycle done is high is ignored. The earliest accepted start is the cycle after done.
- Rotate: after the commit, C equals Y[N-1].
- Y, C and Z change only at a commit edge or at reset.

Decomposition:
- Shared package secuenciador_pkg holds:
  - MODO encodings: MODO_LOG=2'b00, MODO_ARI=2'b01, MODO_ROT=2'b10.
  - State encoding: IDLE, SHIFT, DONE.
- One combinational sub-module, desplazador_1bit_modo.
  - Parameter N; inputs R[N-1:0] and modo[1:0].
  - Outputs: next R[N-1:0] and out bit (R[0]).
  - The controller instantiates it once and calls it every SHIFT cycle.

Test Plan:
- Logical: A=8'hB5, CNT=3, MODO=00 -> Y=8'h16, C=1, Z=0; done exactly 5 cycles after the start edge; busy high for 4 cycles.
- Arithmetic: A=8'hB5, CNT=3, MODO=01 -> Y=8'hF6, C=1, Z=0. Then A=8'h35, CNT=1 -> Y=8'h1A, C=1.
- Rotate: A=8'hB5, CNT=3, MODO=10 -> Y=8'hB6, C=1 (=Y[7]). Then CNT=8 -> Y=8'hB5.
- Boundaries:
  - A=8'h00, CNT=0 -> Y=0, Z=1, C=0, done 2 cycles after start.
  - A=8'hFF, CNT=12, MODO=00 -> clamped to 8: Y=0, Z=1, C=1, done 10 cycles after start.
- Handshake:
  - start pulsed again during SHIFT with A=8'h01 -> ignored; the first result is unaffected.
  - start held high through DONE -> no second operation is launched in that cycle.
- Reset: rst_n driven low mid-SHIFT with no clock edge -> Y=0, C=0, Z=0, busy=0, done=0 immediately. After release, a fresh A=8'h80, CNT=7, MODO=00 -> Y=8'h01, C=0.

Source files
------------

// File: rtl/secuenciador_desplazamiento_pkg.sv
// Shared encodings for the multi-cycle right-shift sequencer: shift modes
// and controller states.
package secuenciador_pkg;

  localparam logic [1:0] MODO_LOG = 2'b00;
  localparam logic [1:0] MODO_ARI = 2'b01;
  localparam logic [1:0] MODO_ROT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/secuenciador_desplazamiento_if.sv
// Control-unit side bundle of the shift sequencer: request, operands and
// the registered result/flags with the busy/done handshake.
interface secuenciador_desplazamiento_if #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
);
  // Handshake: start is honoured only when busy=0; done pulses for one cycle
  // once Y/C/Z hold the new result; start during busy (incl. done) is dropped.
  logic          start;
  logic [N-1:0]  A;
  logic [CW-1:0] CNT;
  logic [1:0]    MODO;
  logic [N-1:0]  Y;
  logic          C;
  logic          Z;
  logic          busy;
  logic          done;

  modport master (output start, A, CNT, MODO, input Y, C, Z, busy, done);
  modport slave  (input start, A, CNT, MODO, output Y, C, Z, busy, done);
endinterface

// File: rtl/secuenciador_desplazamiento_desplazador.sv
// Single-step right shifter: one bit per call, fill bit chosen by mode.
import secuenciador_pkg::*;

module desplazador_1bit_modo #(
  parameter int N = 8
) (
  input  logic [N-1:0] r,
  input  logic [1:0]   modo,
  output logic [N-1:0] r_next,
  output logic         out_bit
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    case (modo)
      MODO_ARI: fill = r[N-1];
      MODO_ROT: fill = r[0];
      default:  fill = 1'b0;  // 2'b11 behaves as logical
    endcase
  end

  assign r_next  = {fill, r[N-1:1]};
  assign out_bit = r[0];

endmodule

// File: rtl/secuenciador_desplazamiento.sv
// Controller that walks an N-bit operand through the 1-bit shifter CNT times
// and commits result, carry and zero flag in one edge.
import secuenciador_pkg::*;

module secuenciador_desplazamiento #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  secuenciador_desplazamiento_if.slave bus,
  output state_t                      state_dbg
);

  state_t        state;
  logic [N-1:0]  r;
  logic [CW-1:0] rem;
  logic [1:0]    modo_r;
  logic          c_int;
  logic [N-1:0]  r_next;
  logic          out_bit;
  logic [CW-1:0] cnt_clamped;

  assign cnt_clamped = (bus.CNT > CW'(N)) ? CW'(N) : bus.CNT;
  assign state_dbg   = state;

  desplazador_1bit_modo #(.N(N)) u_desplazador (
    .r       (r),
    .modo    (modo_r),
    .r_next  (r_next),
    .out_bit (out_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= '0;
      rem      <= '0;
      modo_r   <= MODO_LOG;
      c_int    <= 1'b0;
      bus.Y    <= '0;
      bus.C    <= 1'b0;
      bus.Z    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            r        <= bus.A;
            rem      <= cnt_clamped;
            modo_r   <= bus.MODO;
            c_int    <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem != '0) begin
            r     <= r_next;
            c_int <= out_bit;
            rem   <= rem - 1'b1;
          end else begin
            bus.Y    <= r;
            bus.C    <= c_int;
            bus.Z    <= (r == '0);
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // start seen here is deliberately dropped; next accept is in IDLE.
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_desplazamiento.sv
// Self-checking bench for the shift sequencer: directed cases, handshake
// corner cases, asynchronous reset abort and a randomized batch.
import secuenciador_pkg::*;

module tb_secuenciador_desplazamiento;

  localparam int N = 8;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;

  secuenciador_desplazamiento_if #(.N(N)) bus ();

  secuenciador_desplazamiento #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];   // {Y, C, Z}
  logic [7:0] last_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] a, input logic [3:0] cnt,
                                       input logic [1:0] modo);
    int n;
    logic [7:0] y;
    logic c;
    n = (cnt > 4'd8) ? 8 : int'(cnt);
    case (modo)
      2'b01:   y = 8'($signed(a) >>> n);
      2'b10:   y = (n == 0) ? a : 8'((a >> n) | (a << (8 - n)));
      default: y = a >> n;
    endcase
    c = (n == 0) ? 1'b0 : a[n-1];
    return {y, c, (y == 8'h00)};
  endfunction

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int lat;
    int busy_cycles;
    bit y_stable;
    logic [9:0] exp;
    lat = 1;
    busy_cycles = 0;
    y_stable = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cycles++;
      if (bus.Y !== last_y) y_stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, lat);
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_cycles !== exp_busy) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cycles, exp_busy);
    end
    checks++;
    if (!y_stable) begin
      failures++;
      $display("FAIL %s y_hold: Y changed before commit, required %h", name, last_y);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.Y, bus.C, bus.Z} !== exp) begin
      failures++;
      $display("FAIL %s result: Y=%h C=%b Z=%b required Y=%h C=%b Z=%b",
               name, bus.Y, bus.C, bus.Z, exp[9:2], exp[1], exp[0]);
    end
    last_y = exp[9:2];
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b state=%0d required 0 0 IDLE",
               name, bus.done, bus.busy, state_dbg);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [3:0] cnt, input logic [1:0] modo);
    @(negedge clk);
    bus.A = a; bus.CNT = cnt; bus.MODO = modo; bus.start = 1'b1;
    exp_q.push_back(model(a, cnt, modo));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [3:0] cnt,
                        input logic [1:0] modo);
    int n;
    n = (cnt > 4'd8) ? 8 : int'(cnt);
    launch(a, cnt, modo);
    wait_done(name, n + 2, n + 1);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.A = '0; bus.CNT = '0; bus.MODO = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.Y, bus.C, bus.Z, bus.busy, bus.done} !== 12'h000 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_state: Y=%h C=%b Z=%b busy=%b done=%b state=%0d required all 0 IDLE",
               bus.Y, bus.C, bus.Z, bus.busy, bus.done, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_y = 8'h00;
  endtask

  task automatic test_modes();
    checks++;
    if (model(8'hB5, 4'd3, 2'b00) !== {8'h16, 1'b1, 1'b0} ||
        model(8'hB5, 4'd3, 2'b10) !== {8'hB6, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL model_sanity: logical=%h rotate=%h required 05a 2da",
               model(8'hB5, 4'd3, 2'b00), model(8'hB5, 4'd3, 2'b10));
    end
    run_op("logical_b5_3",  8'hB5, 4'd3, 2'b00);
    run_op("arith_b5_3",    8'hB5, 4'd3, 2'b01);
    run_op("arith_35_1",    8'h35, 4'd1, 2'b01);
    run_op("rotate_b5_3",   8'hB5, 4'd3, 2'b10);
    checks++;
    if (bus.C !== bus.Y[7]) begin
      failures++;
      $display("FAIL rotate_carry: C=%b required Y[7]=%b", bus.C, bus.Y[7]);
    end
    run_op("rotate_b5_8",   8'hB5, 4'd8, 2'b10);
    run_op("mode11_logical", 8'hC3, 4'd2, 2'b11);
  endtask

  task automatic test_boundaries();
    run_op("cnt0_zero",       8'h00, 4'd0,  2'b00);
    run_op("cnt0_passthru",   8'hA7, 4'd0,  2'b01);
    run_op("clamp_logical",   8'hFF, 4'd12, 2'b00);
    run_op("clamp_arith",     8'h80, 4'd15, 2'b01);
    run_op("clamp_rotate",    8'h5A, 4'd9,  2'b10);
  endtask

  task automatic test_start_while_busy();
    launch(8'hB5, 4'd5, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    bus.A = 8'h01; bus.CNT = 4'd0; bus.MODO = 2'b10; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // two samples already consumed since the start edge
    begin
      int lat;
      lat = 3;
      while (!bus.done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (bus.done !== 1'b1 || lat !== 7) begin
        failures++;
        $display("FAIL ignore_start_latency: done=%b at %0d required 1 at 7", bus.done, lat);
      end
    end
    checks++;
    begin
      logic [9:0] exp;
      exp = exp_q.pop_front();
      if ({bus.Y, bus.C, bus.Z} !== exp) begin
        failures++;
        $display("FAIL ignore_start_result: Y=%h C=%b Z=%b required %h %b %b",
                 bus.Y, bus.C, bus.Z, exp[9:2], exp[1], exp[0]);
      end
      last_y = exp[9:2];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.A = 8'h3C; bus.CNT = 4'd2; bus.MODO = 2'b10; bus.start = 1'b1;
    exp_q.push_back(model(8'h3C, 4'd2, 2'b10));
    @(posedge clk); #1;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.done !== 1'b1 || lat !== 4) begin
      failures++;
      $display("FAIL held_start_latency: done=%b at %0d required 1 at 4", bus.done, lat);
    end
    begin
      logic [9:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({bus.Y, bus.C, bus.Z} !== exp) begin
        failures++;
        $display("FAIL held_start_result: Y=%h C=%b Z=%b required %h %b %b",
                 bus.Y, bus.C, bus.Z, exp[9:2], exp[1], exp[0]);
      end
      last_y = exp[9:2];
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL start_in_done_ignored: busy=%b state=%0d required 0 IDLE", bus.busy, state_dbg);
    end
    run_op("after_back_to_back", 8'h96, 4'd4, 2'b01);
  endtask

  task automatic test_async_reset();
    bit done_seen;
    @(negedge clk);
    bus.A = 8'hFF; bus.CNT = 4'd7; bus.MODO = 2'b00; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Y, bus.C, bus.Z, bus.busy, bus.done} !== 12'h000 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL async_reset: Y=%h C=%b Z=%b busy=%b done=%b state=%0d required all 0 IDLE",
               bus.Y, bus.C, bus.Z, bus.busy, bus.done, state_dbg);
    end
    last_y = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.Y !== 8'h00) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      failures++;
      $display("FAIL reset_abort: done or Y update after abort, Y=%h required 00", bus.Y);
    end
    run_op("post_reset_80_7", 8'h80, 4'd7, 2'b00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_op("random", 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_modes();
    test_boundaries();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
